// File: rtl/tempsens_meas_seq.sv
// Measurement sequencer for the ring-oscillator temperature sensor array.
// On a start it resets the sensor counters, lets them settle, enables them,
// collects each selected sensor's DOUT once its DONE is stable, and then
// raises a completion pulse and interrupt. A timeout bounds the CONVERT phase.
module tempsens_meas_seq #(
   parameter int NumSensors   = 4,
   parameter int DoutW        = 24,
   parameter int TimeoutW     = 20,
   parameter int SettleCycles = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [NumSensors-1:0]         sensor_mask_i,
   input  logic [3:0]                    conv_time_i,
   input  logic [TimeoutW-1:0]           timeout_i,
   input  logic                          irq_clr_i,
   input  logic [NumSensors-1:0]         sens_done_i,
   input  logic [NumSensors*DoutW-1:0]   sens_dout_i,
   output logic                          sens_reset_no,
   output logic [3:0]                    sens_conv_time_o,
   output logic                          sens_en_o,
   output logic                          busy_o,
   output logic [NumSensors*DoutW-1:0]   result_o,
   output logic [NumSensors-1:0]         result_valid_o,
   output logic [NumSensors-1:0]         timeout_err_o,
   output logic                          done_o,
   output logic                          irq_o
);

   localparam int CntW = $clog2(SettleCycles + 1) + 1;

   typedef enum logic [2:0] {
      StIdle,
      StRst,
      StSettle,
      StConvert,
      StFinish
   } state_e;

   state_e                        state_q, state_d;
   logic [CntW-1:0]               cnt_q, cnt_d;
   logic [TimeoutW-1:0]           timer_q, timer_d;
   logic [TimeoutW-1:0]           tmo_q, tmo_d;
   logic [NumSensors-1:0]         mask_q, mask_d;
   logic [3:0]                    conv_q, conv_d;
   logic [NumSensors*DoutW-1:0]   result_q, result_d;
   logic [NumSensors-1:0]         valid_q, valid_d;
   logic [NumSensors-1:0]         err_q, err_d;
   logic                          reset_n_q, reset_n_d;
   logic                          en_q, en_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          irq_q, irq_d;

   logic [NumSensors-1:0]         sync1_q, done_s_q, done_h_q;
   logic [NumSensors-1:0]         stable;

   // DONE crosses from the sensor clock: two-flop sync plus one history stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q  <= '0;
         done_s_q <= '0;
         done_h_q <= '0;
      end else begin
         sync1_q  <= sens_done_i;
         done_s_q <= sync1_q;
         done_h_q <= done_s_q;
      end
   end

   // Stable means the synchronized DONE has been high for two cycles in a row
   assign stable = done_s_q & done_h_q;

   // Next-state, capture and output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      tmo_d    = tmo_q;
      mask_d   = mask_q;
      conv_d   = conv_q;
      result_d = result_q;
      valid_d  = valid_q;
      err_d    = err_q;

      case (state_q)
         StIdle: begin
            if (start_i && !abort_i && (sensor_mask_i != '0)) begin
               state_d = StRst;
               cnt_d   = '0;
               mask_d  = sensor_mask_i;
               conv_d  = conv_time_i;
               tmo_d   = timeout_i;
               valid_d = '0;
               err_d   = '0;
            end
         end
         // One extra state cycle up front so the reset pulse itself spans
         // exactly SettleCycles cycles once the registered output follows.
         StRst: begin
            if (cnt_q == CntW'(SettleCycles)) begin
               state_d = StSettle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StSettle: begin
            if (cnt_q == CntW'(SettleCycles - 1)) begin
               state_d = StConvert;
               timer_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StConvert: begin
            for (int i = 0; i < NumSensors; i++) begin
               if (mask_q[i] && !valid_q[i] && stable[i]) begin
                  result_d[i*DoutW +: DoutW] = sens_dout_i[i*DoutW +: DoutW];
                  valid_d[i]                 = 1'b1;
               end
            end
            // Completion is judged on this edge's captures, so a last capture
            // coinciding with the timeout counts as a success.
            if ((valid_d & mask_q) == mask_q) begin
               state_d = StFinish;
            end else if ((tmo_q != '0) && (timer_q == tmo_q - TimeoutW'(1))) begin
               state_d = StFinish;
               err_d   = mask_q & ~valid_d;
            end
            if (timer_q != {TimeoutW{1'b1}}) timer_d = timer_q + TimeoutW'(1);
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase

      if (abort_i && (state_q != StIdle)) begin
         state_d = StIdle;
         err_d   = err_q;
      end

      reset_n_d = !((state_q == StRst) && (state_d == StRst));
      en_d      = (state_d == StConvert);
      busy_d    = (state_d != StIdle);
      done_d    = (state_d == StFinish);
      irq_d     = done_d | (irq_q & ~irq_clr_i);
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         timer_q   <= '0;
         tmo_q     <= '0;
         mask_q    <= '0;
         conv_q    <= '0;
         result_q  <= '0;
         valid_q   <= '0;
         err_q     <= '0;
         reset_n_q <= 1'b1;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         tmo_q     <= tmo_d;
         mask_q    <= mask_d;
         conv_q    <= conv_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         reset_n_q <= reset_n_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
      end
   end

   assign sens_reset_no    = reset_n_q;
   assign sens_conv_time_o = conv_q;
   assign sens_en_o        = en_q;
   assign busy_o           = busy_q;
   assign result_o         = result_q;
   assign result_valid_o   = valid_q;
   assign timeout_err_o    = err_q;
   assign done_o           = done_q;
   assign irq_o            = irq_q;

endmodule

// File: tb/tb_tempsens_meas_seq.sv
// Bench for tempsens_meas_seq: directed scenarios plus randomized measurements
// checked against a timing model of the sequence expressed in edge numbers.
module tb_tempsens_meas_seq;

   localparam int NS = 4;
   localparam int DW = 24;
   localparam int TW = 20;
   localparam int S  = 8;
   localparam int CE = 2 * S + 1;   // edge at which CONVERT/en begin
   localparam int NEVER = 1 << 30;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             start_i, abort_i, irq_clr_i;
   logic [NS-1:0]    sensor_mask_i;
   logic [3:0]       conv_time_i;
   logic [TW-1:0]    timeout_i;
   logic [NS-1:0]    sens_done_i;
   logic [NS*DW-1:0] sens_dout_i;
   logic             sens_reset_no, sens_en_o, busy_o, done_o, irq_o;
   logic [3:0]       sens_conv_time_o;
   logic [NS*DW-1:0] result_o;
   logic [NS-1:0]    result_valid_o, timeout_err_o;

   tempsens_meas_seq #(.NumSensors(NS), .DoutW(DW), .TimeoutW(TW), .SettleCycles(S)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .sensor_mask_i(sensor_mask_i), .conv_time_i(conv_time_i), .timeout_i(timeout_i),
      .irq_clr_i(irq_clr_i), .sens_done_i(sens_done_i), .sens_dout_i(sens_dout_i),
      .sens_reset_no(sens_reset_no), .sens_conv_time_o(sens_conv_time_o),
      .sens_en_o(sens_en_o), .busy_o(busy_o), .result_o(result_o),
      .result_valid_o(result_valid_o), .timeout_err_o(timeout_err_o),
      .done_o(done_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          d[NS];          // edge after which DONE i is driven high
   int          len[NS];        // number of cycles DONE i stays high
   logic [23:0] dv[NS];         // DOUT per sensor for the current run
   logic [23:0] exp_res[NS];    // expected held results
   logic        exp_irq;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_irq();
      @(posedge clk_i); #1 irq_clr_i = 1'b1;
      @(posedge clk_i); #1 irq_clr_i = 1'b0;
      @(negedge clk_i);
      chk("irq_clr", 96'(irq_o), 96'(1'b0));
      exp_irq = 1'b0;
   endtask

   // One measurement: start sampled at edge 0; checks every cycle up to the end.
   // clr_at = -2 means "drive irq_clr so it lands on the FINISH edge".
   task automatic run_meas(input logic [3:0] mask, input logic [3:0] conv, input int tmo,
                           input int abort_at, input int bstart_at, input int clr_at_in);
      int cap[NS];
      int fin, maxcap, kend, endst, clr_at, c;
      bit allcap, ab;
      logic [3:0] ev, ee;
      ab = (abort_at >= 0);
      maxcap = 0; allcap = 1'b1;
      for (int i = 0; i < NS; i++) begin
         c = d[i] + 4;                // 2 sync flops + 2 cycles high, captured next edge
         if (c < CE + 1) c = CE + 1;  // captures only happen while converting
         cap[i] = (c <= d[i] + len[i] + 2) ? c : NEVER;
         if (mask[i]) begin
            if (cap[i] == NEVER) allcap = 1'b0;
            else if (cap[i] > maxcap) maxcap = cap[i];
         end
      end
      if (allcap && (tmo == 0 || maxcap <= CE + tmo)) fin = maxcap;
      else fin = CE + tmo;
      ev = '0;
      for (int i = 0; i < NS; i++) ev[i] = !ab && mask[i] && (cap[i] <= fin);
      ee = ab ? 4'b0 : (mask & ~ev);
      endst  = ab ? abort_at : fin;
      kend   = endst + 2;
      clr_at = (clr_at_in == -2) ? fin - 1 : clr_at_in;

      @(posedge clk_i); #1;
      start_i = 1'b1; sensor_mask_i = mask; conv_time_i = conv; timeout_i = TW'(tmo);
      for (int i = 0; i < NS; i++) sens_dout_i[i*DW +: DW] = dv[i];
      sens_done_i = '0;
      @(posedge clk_i);
      for (int k = 0; k <= kend; k++) begin
         if (k > 0) @(posedge clk_i);
         #1;
         start_i = (k == bstart_at);
         if (k == bstart_at) sensor_mask_i = ~mask;
         abort_i   = (k == abort_at);
         irq_clr_i = (k == clr_at);
         for (int i = 0; i < NS; i++) sens_done_i[i] = (k >= d[i]) && (k < d[i] + len[i]);
         @(negedge clk_i);
         if (!ab && k == fin) exp_irq = 1'b1;
         else if (k > 0 && clr_at == k - 1) exp_irq = 1'b0;
         chk($sformatf("rstn@%0d", k), 96'(sens_reset_no), 96'(!(k >= 1 && k <= S)));
         chk($sformatf("en@%0d", k), 96'(sens_en_o), 96'(k >= CE && k <= (ab ? abort_at : fin - 1)));
         chk($sformatf("busy@%0d", k), 96'(busy_o), 96'(k <= endst));
         chk($sformatf("done@%0d", k), 96'(done_o), 96'(!ab && k == fin));
         chk($sformatf("irq@%0d", k), 96'(irq_o), 96'(exp_irq));
         chk($sformatf("conv@%0d", k), 96'(sens_conv_time_o), 96'(conv));
      end
      abort_i = 1'b0; irq_clr_i = 1'b0;
      for (int i = 0; i < NS; i++) if (ev[i]) exp_res[i] = dv[i];
      chk("valid", 96'(result_valid_o), 96'(ev));
      chk("tmo_err", 96'(timeout_err_o), 96'(ee));
      for (int i = 0; i < NS; i++)
         chk($sformatf("result%0d", i), 96'(result_o[i*DW +: DW]), 96'(exp_res[i]));
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; irq_clr_i = 1'b0;
      sensor_mask_i = '0; conv_time_i = '0; timeout_i = '0;
      sens_done_i = '0; sens_dout_i = '0;
      exp_irq = 1'b0;
      for (int i = 0; i < NS; i++) exp_res[i] = '0;

      // Reset values
      #12;
      chk("rst_rstn", 96'(sens_reset_no), 96'(1'b1));
      chk("rst_en", 96'(sens_en_o), 96'(1'b0));
      chk("rst_busy", 96'(busy_o), 96'(1'b0));
      chk("rst_result", 96'(result_o), 96'(0));
      chk("rst_irq", 96'({irq_o, done_o, result_valid_o, timeout_err_o, sens_conv_time_o}), 96'(0));
      @(negedge clk_i); rst_ni = 1'b1;

      // All four sensors, no timeout
      for (int i = 0; i < NS; i++) begin d[i] = 40 + 10 * i; len[i] = 1000; dv[i] = 24'h00A5A0 + 24'(i); end
      run_meas(4'b1111, 4'h3, 0, -1, -1, -1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_i); chk("irq_hold", 96'(irq_o), 96'(1'b1));
      end
      clr_irq();

      // Sensor 2 never finishes: timeout
      d[0] = 50; d[1] = 0; d[2] = NEVER; d[3] = 0;
      len[0] = 1000; len[1] = 1000; len[2] = 0; len[3] = 1000;
      for (int i = 0; i < NS; i++) dv[i] = 24'h123400 + 24'(i);
      run_meas(4'b0101, 4'h1, 100, -1, -1, -1);
      clr_irq();

      // One-cycle DONE is not stable; three-cycle DONE is
      d[0] = 30; len[0] = 1; d[1] = 35; len[1] = 3; d[2] = 0; len[2] = 0; d[3] = 0; len[3] = 0;
      for (int i = 0; i < NS; i++) dv[i] = 24'hBEEF00 + 24'(i);
      run_meas(4'b0011, 4'h7, 60, -1, -1, -1);
      clr_irq();

      // Abort five cycles into CONVERT
      for (int i = 0; i < NS; i++) begin d[i] = NEVER; len[i] = 0; dv[i] = 24'hFFFFFF; end
      run_meas(4'b1111, 4'h2, 0, CE + 4, -1, -1);
      // start with an empty mask, then start together with abort: both ignored
      @(posedge clk_i); #1 start_i = 1'b1; sensor_mask_i = '0;
      @(posedge clk_i); #1 start_i = 1'b1; abort_i = 1'b1; sensor_mask_i = 4'hF;
      @(posedge clk_i); #1 start_i = 1'b0; abort_i = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_i);
         chk("idle_busy", 96'(busy_o), 96'(1'b0));
         chk("idle_rstn", 96'(sens_reset_no), 96'(1'b1));
         chk("idle_done", 96'(done_o), 96'(1'b0));
      end

      // start while busy ignored; irq_clr coincident with FINISH loses
      d[0] = 10; d[1] = 20; d[2] = 30; d[3] = 5;
      for (int i = 0; i < NS; i++) begin len[i] = 1000; dv[i] = 24'h5A5A00 + 24'(i); end
      run_meas(4'b0110, 4'h9, 0, -1, 25, -2);
      clr_irq();

      // Randomized measurements
      for (int t = 0; t < 10; t++) begin
         logic [3:0] m;
         int tmo;
         m = 4'($urandom_range(1, 15));
         tmo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(20, 80));
         for (int i = 0; i < NS; i++) begin
            d[i]  = $urandom_range(0, 70);
            case ($urandom_range(0, 3))
               0: len[i] = 1;
               1: len[i] = 2;
               2: len[i] = 3;
               default: len[i] = 500;
            endcase
            if (tmo == 0) len[i] = 500;
            dv[i] = 24'($urandom);
         end
         run_meas(m, 4'($urandom), tmo, -1, -1, -1);
         clr_irq();
      end

      // Async reset during CONVERT
      for (int i = 0; i < NS; i++) begin d[i] = NEVER; len[i] = 0; end
      @(posedge clk_i); #1 start_i = 1'b1; sensor_mask_i = 4'hF; timeout_i = '0;
      @(posedge clk_i); #1 start_i = 1'b0;
      repeat (CE + 3) @(posedge clk_i);
      #1;
      chk("pre_rst_en", 96'(sens_en_o), 96'(1'b1));
      #2 rst_ni = 1'b0;
      #1;
      chk("arst_en", 96'(sens_en_o), 96'(1'b0));
      chk("arst_rstn", 96'(sens_reset_no), 96'(1'b1));
      chk("arst_busy", 96'(busy_o), 96'(1'b0));
      chk("arst_result", 96'(result_o), 96'(0));
      chk("arst_misc", 96'({irq_o, done_o, result_valid_o, timeout_err_o, sens_conv_time_o}), 96'(0));
      @(negedge clk_i); rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_busy", 96'(busy_o), 96'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
